divider: RTL and testbench

//  Sequential signed integer divider; inverse of the team's Booth multiplier.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 28 ++
 rtl/divider.sv | 137 +++++++++++++
 tb/tb_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // Default operand / quotient / remainder width.
    localparam int DEF_WIDTH = 32;

    // Controller states, encoded so the debug port reads the same everywhere.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The partial remainder is shifted left with the next dividend bit appended.
// The divisor is subtracted only when the shifted value is at least the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0] rem_in,
    input  logic [WIDTH:0] dsr_mag,
    input  logic           bit_in,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   shifted;

    assign trial   = {rem_in, bit_in};
    assign shifted = {rem_in[WIDTH-1:0], bit_in};

    // Compare the shifted remainder with the divisor, then either keep the difference or restore.
    always_comb begin
        q_bit   = (trial >= {1'b0, dsr_mag});
        rem_out = q_bit ? (shifted - dsr_mag) : shifted;
    end

endmodule

// File: rtl/divider.sv
// Sequential signed divider, one quotient bit per clock.
// Handshake: op_start is accepted only in IDLE. The result is valid while op_done=1.
// It is held until op_clear or reset. op_clear wins over op_start in the same cycle.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             op_done,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    // Holds the not-yet-consumed dividend bits on the left and the quotient bits shifted in on the right.
    logic [WIDTH-1:0] work;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dsr_mag;
    logic             dvd_neg;
    logic             dsr_neg;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;
    logic [WIDTH-1:0] mag_q;
    logic             div_zero;
    logic             last_step;

    // The magnitude of -2^(WIDTH-1) still fits in WIDTH bits when read as unsigned.
    assign dvd_abs   = dividend[WIDTH-1] ? -dividend : dividend;
    assign dsr_abs   = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign div_zero  = (divisor == '0);
    assign last_step = (state == BUSY) && (count == CW'(WIDTH - 1));
    assign mag_q     = {work[WIDTH-2:0], step_q};
    assign state_dbg = state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dsr_mag (dsr_mag),
        .bit_in  (work[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: clear first, then start or finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op_clear)      state_next = IDLE;
                else if (op_start) state_next = div_zero ? DONE : BUSY;
            end
            BUSY: begin
                if (op_clear)       state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: begin
                if (op_clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, sign fixup and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            work        <= '0;
            rem         <= '0;
            dsr_mag     <= '0;
            dvd_neg     <= 1'b0;
            dsr_neg     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (op_clear) begin
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        if (div_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            op_done     <= 1'b1;
                        end else begin
                            work    <= dvd_abs;
                            rem     <= '0;
                            dsr_mag <= {1'b0, dsr_abs};
                            dvd_neg <= dividend[WIDTH-1];
                            dsr_neg <= divisor[WIDTH-1];
                            count   <= '0;
                        end
                    end
                end
                BUSY: begin
                    work  <= mag_q;
                    rem   <= step_rem;
                    count <= count + 1'b1;
                    if (last_step) begin
                        // The quotient is negated when the operand signs differ; the remainder follows the dividend sign.
                        quotient  <= (dvd_neg ^ dsr_neg) ? -mag_q : mag_q;
                        remainder <= dvd_neg ? WIDTH'(-step_rem) : WIDTH'(step_rem);
                        op_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the sequential signed divider.
module tb_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         op_done;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected results {div_by_zero, quotient, remainder}, in completion order.
    logic [2*W:0] exp_q[$];

    divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .op_done     (op_done),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: signed division with truncation toward zero, 32-bit wrap, and divide-by-zero rule.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, q[W-1:0], r[W-1:0]};
    endfunction

    // Compare process: while op_done is high the outputs must equal the model result; otherwise all must be zero.
    logic [2*W:0] cur;
    bit           have_cur = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (op_done) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: got op_done=1 required no result pending");
                        cur = '1;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    have_cur = 1'b1;
                end
                check("result", {div_by_zero, quotient, remainder}, cur);
            end else begin
                have_cur = 1'b0;
                check("outputs_idle", {div_by_zero, quotient, remainder}, '0);
            end
        end
    end

    // Driver: start one divide, scramble inputs after capture, and measure op_done latency.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
        int n;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        op_start = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n = 0;
        while (!op_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", (2*W+1)'(n), (2*W+1)'(exp_lat));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input int cycles);
        @(negedge clk);
        op_start = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (cycles - 1) @(posedge clk);
    endtask

    logic [W-1:0] vec_a[12];
    logic [W-1:0] vec_b[12];

    initial begin
        // Hand-computed pins of the model itself.
        check("model_100_7",   model(32'd100, 32'd7),                {1'b0, 32'd14, 32'd2});
        check("model_m100_7",  model(-32'sd100, 32'd7),              {1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE});
        check("model_100_m7",  model(32'd100, -32'sd7),              {1'b0, 32'hFFFFFFF2, 32'd2});
        check("model_5_0",     model(32'd5, 32'd0),                  {1'b1, 32'hFFFFFFFF, 32'd5});
        check("model_min_m1",  model(32'h80000000, 32'hFFFFFFFF),    {1'b0, 32'h80000000, 32'd0});
        check("model_min_1",   model(32'h80000000, 32'd1),           {1'b0, 32'h80000000, 32'd0});

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_state", {state_dbg, op_done, div_by_zero, quotient, remainder}, '0);
        reset_n = 1'b1;

        vec_a = '{32'd100, -32'sd100, 32'd100, 32'd5, 32'h80000000, 32'h80000000,
                  -32'sd7, 32'd0, 32'd7, 32'h7FFFFFFF, 32'h80000000, -32'sd1};
        vec_b = '{32'd7, 32'd7, -32'sd7, 32'd0, 32'hFFFFFFFF, 32'd1,
                  -32'sd2, 32'd5, 32'd100, 32'd2, 32'h80000000, 32'h7FFFFFFF};

        for (int i = 0; i < 12; i++) begin
            run_div(vec_a[i], vec_b[i], (vec_b[i] == '0) ? 0 : W);
            if (i == 0) check("dut_100_7_lit", {div_by_zero, quotient, remainder}, {1'b0, 32'd14, 32'd2});
            if (i == 3) check("dut_5_0_lit", {div_by_zero, quotient, remainder}, {1'b1, 32'hFFFFFFFF, 32'd5});
            do_clear();
        end

        // op_clear mid-BUSY aborts; a fresh divide follows.
        start_and_wait(32'd1000, 32'd3, 10);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_abort", {state_dbg, op_done, div_by_zero, quotient, remainder}, '0);
        @(negedge clk);
        op_clear = 1'b0;
        run_div(32'd9, 32'd2, W);
        check("after_clear_lit", {div_by_zero, quotient, remainder}, {1'b0, 32'd4, 32'd1});
        do_clear();

        // Asynchronous reset mid-BUSY aborts; the same recovery follows.
        start_and_wait(32'd1000, 32'd3, 10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_abort", {state_dbg, op_done, div_by_zero, quotient, remainder}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_div(32'd9, 32'd2, W);

        // In DONE a new op_start is ignored; the compare process keeps checking the held result.
        @(negedge clk);
        op_start = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk);
        op_start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_hold", {(2*W-1)'(state_dbg), op_done, quotient}, {(2*W-1)'(2'b10), 1'b1, 32'd4});

        // op_clear together with op_start: back to IDLE and the start is dropped.
        @(negedge clk);
        op_clear = 1'b1;
        op_start = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd7;
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        check("clear_wins", {(2*W-1)'(state_dbg), op_done}, '0);
        repeat (40) @(negedge clk);
        check("start_dropped", {(2*W-1)'(state_dbg), op_done}, '0);
        check("queue_drained", (2*W+1)'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
